// File: rtl/popcnt_arb.sv
// Round-robin arbiter sharing one popcount engine among NREQ requesters.
// Optional WAIT-state timeout is built when POPCNT_ARB_TIMEOUT_EN is defined.
module popcnt_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int PW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        a_flat,
    output logic [NREQ-1:0]          ack,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [PW-1:0]            rsp_p,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     eng_start,
    output logic [W-1:0]             eng_a,
    input  logic                     eng_done,
    input  logic [PW-1:0]            eng_p
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_badParams
        $error("popcnt_arb: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   rrPtr_q, rrPtr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [W-1:0]    engA_q, engA_d;
    logic [PW-1:0]   rspP_q, rspP_d;
    logic [IW-1:0]   rspId_q, rspId_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            rspValid_q, rspValid_d;
    logic            busy_q, busy_d;
    logic            engStart_q, engStart_d;
    logic            grantValid;
    logic [IW-1:0]   grantId;
    logic            timedOut;
    logic [IW-1:0]   idNext;

`ifdef POPCNT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] toCnt_q, toCnt_d;
    logic          rspErr_q, rspErr_d;

    assign timedOut = (state_q == WAIT) && !eng_done && (toCnt_q == CW'(TIMEOUT - 1));
`else
    assign timedOut = 1'b0;
`endif

    // First requester at or after rrPtr_q, wrapping at NREQ-1.
    always_comb begin
        int idx;
        idx        = 0;
        grantValid = 1'b0;
        grantId    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rrPtr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grantValid && req[idx]) begin
                grantValid = 1'b1;
                grantId    = IW'(idx);
            end
        end
    end

    assign idNext = (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);

    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        id_d    = id_q;
        engA_d  = engA_q;
        rspP_d  = rspP_q;
        rspId_d = rspId_q;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    state_d = LAUNCH;
                    id_d    = grantId;
                    engA_d  = a_flat[grantId*W +: W];
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (eng_done || timedOut) begin
                    state_d = RESP;
                    rspP_d  = eng_done ? eng_p : '0;
                    rspId_d = id_q;
                    rrPtr_d = idNext;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        ack_d      = (state_d == RESP) ? (NREQ'(1) << id_q) : '0;
        rspValid_d = (state_d == RESP);
        busy_d     = (state_d != IDLE);
        engStart_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            id_q       <= '0;
            engA_q     <= '0;
            rspP_q     <= '0;
            rspId_q    <= '0;
            ack_q      <= '0;
            rspValid_q <= 1'b0;
            busy_q     <= 1'b0;
            engStart_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            id_q       <= id_d;
            engA_q     <= engA_d;
            rspP_q     <= rspP_d;
            rspId_q    <= rspId_d;
            ack_q      <= ack_d;
            rspValid_q <= rspValid_d;
            busy_q     <= busy_d;
            engStart_q <= engStart_d;
        end
    end

`ifdef POPCNT_ARB_TIMEOUT_EN
    // A done on the limit cycle wins over the timeout.
    always_comb begin
        toCnt_d  = toCnt_q;
        rspErr_d = rspErr_q;
        if (state_q == LAUNCH) begin
            toCnt_d = '0;
        end else if (state_q == WAIT) begin
            toCnt_d = toCnt_q + CW'(1);
            if (eng_done)      rspErr_d = 1'b0;
            else if (timedOut) rspErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toCnt_q  <= '0;
            rspErr_q <= 1'b0;
        end else begin
            toCnt_q  <= toCnt_d;
            rspErr_q <= rspErr_d;
        end
    end

    assign rsp_err = rspErr_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign ack       = ack_q;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_p     = rspP_q;
    assign busy      = busy_q;
    assign eng_start = engStart_q;
    assign eng_a     = engA_q;

endmodule

// File: tb/tb_popcnt_arb.sv
// Scoreboard bench for popcnt_arb with a behavioural popcount engine.
// Build with POPCNT_ARB_TIMEOUT_EN defined to exercise the timeout path.
module tb_popcnt_arb;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int PW      = 8;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [31:0]     a_flat;
    logic [3:0]      ack;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_p;
    logic            rsp_err;
    logic            busy;
    logic            eng_start;
    logic [7:0]      eng_a;
    logic            eng_done = 1'b0;
    logic [7:0]      eng_p = 8'h00;

    typedef struct {
        logic [1:0] id;
        logic [7:0] p;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       sbQ[$];
    logic [7:0] opQ[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int startCyc = 0;

    bit         engOn = 1'b1;
    int         engLat = 3;
    bit         spurIdle = 1'b0;
    bit         spurLaunch = 1'b0;
    bit         pend = 1'b0;
    int         engCnt = 0;
    logic [7:0] engVal = 8'h00;

    int pendingRe = 0;
    bit reassert0 = 1'b0;

    popcnt_arb #(.NREQ(NREQ), .W(W), .PW(PW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_flat    (a_flat),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_done  (eng_done),
        .eng_p     (eng_p)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " ack"}, 32'(ack), 0);
        checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 0);
        checkOutput({name, " rsp_id"}, 32'(rsp_id), 0);
        checkOutput({name, " rsp_p"}, 32'(rsp_p), 0);
        checkOutput({name, " rsp_err"}, 32'(rsp_err), 0);
        checkOutput({name, " busy"}, 32'(busy), 0);
        checkOutput({name, " eng_start"}, 32'(eng_start), 0);
        checkOutput({name, " eng_a"}, 32'(eng_a), 0);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] a);
        a_flat = a;
        req    = req | r;
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        #1;
        checkIdle(name);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitDrained(input int budget, input string name);
        int n;
        n = 0;
        while (!(sbQ.size() == 0 && !busy && req == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " pending responses"}, 32'(sbQ.size()), 0);
        sbQ.delete();
    endtask

    // Engine model: done pulse engLat cycles after start, result = popcount.
    initial begin
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (pend) begin
                engCnt--;
                if (engCnt == 0) begin
                    eng_done = 1'b1;
                    eng_p    = engVal;
                    pend     = 1'b0;
                end
            end
            if (spurIdle) begin
                eng_done = 1'b1;
                eng_p    = 8'hAA;
                spurIdle = 1'b0;
            end
            if (eng_start) begin
                if (spurLaunch) begin
                    eng_done   = 1'b1;
                    eng_p      = 8'hAA;
                    spurLaunch = 1'b0;
                end
                if (engOn) begin
                    pend   = 1'b1;
                    engCnt = engLat;
                    engVal = 8'($countones(eng_a));
                end
            end
        end
    end

    // Requesters drop req on ack; client 0 may reassert two cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (pendingRe > 0) begin
                pendingRe--;
                if (pendingRe == 0) req[0] = 1'b1;
            end
            if (ack != 0) begin
                req = req & ~ack;
                if (ack[0] && reassert0) begin
                    reassert0 = 1'b0;
                    pendingRe = 2;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response and every launch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (eng_start) begin
                startCyc = cyc;
                if (opQ.size() == 0) checkOutput("unexpected eng_start", 32'(eng_start), 0);
                else checkOutput("eng_a", 32'(eng_a), 32'(opQ.pop_front()));
            end
            if (rsp_valid) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected rsp_valid", 32'(rsp_valid), 0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_p", 32'(rsp_p), 32'(e.p));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                    checkOutput("ack onehot", 32'(ack), 32'(4'b0001 << e.id));
                    checkOutput("start to ack latency", 32'(cyc - startCyc), 32'(e.lat));
                end
            end else if (ack != 0) begin
                checkOutput("ack without rsp_valid", 32'(ack), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset  = 1'b1;
        req    = '0;
        a_flat = '0;
        repeat (2) @(negedge clk);
        checkIdle("reset");
        reset = 1'b0;

        // Single job: 8'hB5 has five ones, engine latency 9.
        @(negedge clk);
        engLat = 9;
        opQ.push_back(8'hB5);
        sbQ.push_back('{2'd0, 8'd5, 1'b0, 10});
        applyStimulus(4'b0001, 32'h0000_00B5);
        @(negedge clk);
        checkOutput("eng_start one cycle after req", 32'(eng_start), 1);
        waitDrained(100, "single job");
        repeat (2) @(negedge clk);
        checkOutput("rsp_p held", 32'(rsp_p), 5);
        checkOutput("rsp_valid low after resp", 32'(rsp_valid), 0);

        // Round robin from rr_ptr=0 with client 0 reasserting once.
        doReset("reset before rr");
        engLat = 3;
        opQ.push_back(8'h00); opQ.push_back(8'hFF); opQ.push_back(8'h0F);
        opQ.push_back(8'h01); opQ.push_back(8'h00);
        sbQ.push_back('{2'd0, 8'd0, 1'b0, 4});
        sbQ.push_back('{2'd1, 8'd8, 1'b0, 4});
        sbQ.push_back('{2'd2, 8'd4, 1'b0, 4});
        sbQ.push_back('{2'd3, 8'd1, 1'b0, 4});
        sbQ.push_back('{2'd0, 8'd0, 1'b0, 4});
        reassert0 = 1'b1;
        applyStimulus(4'b1111, 32'h010F_FF00);
        waitDrained(300, "round robin");

        // Pointer wrap: serve 3, then 0 and 3 together -> 0 first.
        opQ.push_back(8'h81);
        sbQ.push_back('{2'd3, 8'd2, 1'b0, 4});
        applyStimulus(4'b1000, 32'h8100_0000);
        waitDrained(100, "serve id3");
        opQ.push_back(8'h7F); opQ.push_back(8'hC3);
        sbQ.push_back('{2'd0, 8'd7, 1'b0, 4});
        sbQ.push_back('{2'd3, 8'd4, 1'b0, 4});
        applyStimulus(4'b1001, 32'hC300_007F);
        waitDrained(200, "pointer wrap");

        // Spurious done in IDLE and in LAUNCH.
        spurIdle = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("busy after idle done", 32'(busy), 0);
        spurLaunch = 1'b1;
        engLat = 4;
        opQ.push_back(8'h3C);
        sbQ.push_back('{2'd1, 8'd4, 1'b0, 5});
        applyStimulus(4'b0010, 32'h0000_3C00);
        waitDrained(100, "launch done ignored");

        // Reset two cycles after launch; late engine done must be ignored.
        engLat = 20;
        opQ.push_back(8'hFF);
        applyStimulus(4'b0010, 32'h0000_FF00);
        n = 0;
        while (!eng_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reset test launch", 32'(eng_start), 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        req   = '0;
        #1;
        checkIdle("reset mid wait");
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("busy after late done", 32'(busy), 0);
        engLat = 3;
        opQ.push_back(8'h01); opQ.push_back(8'h55);
        sbQ.push_back('{2'd1, 8'd1, 1'b0, 4});
        sbQ.push_back('{2'd2, 8'd4, 1'b0, 4});
        applyStimulus(4'b0110, 32'h0055_0100);
        waitDrained(200, "after reset");

`ifdef POPCNT_ARB_TIMEOUT_EN
        // Engine silent: response after 16 WAIT cycles with error.
        engOn = 1'b0;
        opQ.push_back(8'h0F);
        sbQ.push_back('{2'd0, 8'd0, 1'b1, 17});
        applyStimulus(4'b0001, 32'h0000_000F);
        waitDrained(100, "timeout");
        // Done on the limit cycle wins and clears the error.
        engOn  = 1'b1;
        engLat = 16;
        opQ.push_back(8'h03);
        sbQ.push_back('{2'd1, 8'd2, 1'b0, 17});
        applyStimulus(4'b0010, 32'h0000_0300);
        waitDrained(100, "done on limit");
`else
        // Without the timeout the arbiter waits forever.
        engOn = 1'b0;
        opQ.push_back(8'h0F);
        applyStimulus(4'b0001, 32'h0000_000F);
        repeat (200) @(negedge clk);
        checkOutput("busy without timeout", 32'(busy), 1);
        doReset("reset after hang");
        engOn = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
